// File: rtl/crypto_csr_pkg.sv
// Shared definitions for the crypto CSR block: FSM encodings, CTRL/STATUS
// bit positions and register-map address helpers.
package crypto_csr_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LAUNCH = 2'd1;
   localparam logic [1:0] ST_BUSY   = 2'd2;

   localparam int CTRL_START = 0;
   localparam int CTRL_ABORT = 1;
   localparam int CTRL_IE    = 2;

   localparam int STAT_DONE  = 0;
   localparam int STAT_BUSY  = 1;
   localparam int STAT_ERR   = 2;

   function automatic int in_base(input int k);
      return k;
   endfunction

   function automatic int out_base(input int k, input int m);
      return k + m;
   endfunction

   function automatic int ctrl_addr(input int aw);
      return (1 << aw) - 2;
   endfunction

   function automatic int status_addr(input int aw);
      return (1 << aw) - 1;
   endfunction

endpackage

// File: rtl/crypto_csr_fsm.sv
// Launch/busy/done sequencer for the crypto core: one-cycle CORE_START in
// LAUNCH, result capture on CORE_DONE in BUSY, abort back to IDLE with a
// one-cycle CORE_CLR, and the completed-operation counter.
module crypto_csr_fsm
   import crypto_csr_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             start_req,
   input  logic             abort_req,
   input  logic             CORE_DONE,
   output logic             CORE_START,
   output logic             CORE_CLR,
   output logic             busy,
   output logic             capture,
   output logic [CNT_W-1:0] op_count
);

   logic [1:0] state, state_nx;

   // Next-state logic; abort has priority over a simultaneous CORE_DONE
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (start_req) state_nx = ST_LAUNCH;
         ST_LAUNCH: state_nx = abort_req ? ST_IDLE : ST_BUSY;
         ST_BUSY:   if (abort_req || CORE_DONE) state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   assign busy       = (state != ST_IDLE);
   assign CORE_START = (state == ST_LAUNCH);
   assign capture    = (state == ST_BUSY) && CORE_DONE && !abort_req;

   // State, abort pulse and completion counter
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= ST_IDLE;
         CORE_CLR <= 1'b0;
         op_count <= '0;
      end else begin
         state    <= state_nx;
         CORE_CLR <= abort_req && busy;
         if (capture) op_count <= op_count + 1'b1;
      end
   end

endmodule

// File: rtl/avalon_crypto_csr.sv
// Avalon-MM register file and launch controller for a multi-cycle crypto
// core. KEY/IN are byte-writable and locked while an operation runs, OUT
// captures the core result, CTRL carries START/ABORT/IE, STATUS carries
// DONE/BUSY/ERR and the completed-operation count.
// Optional build macro CRYPTO_CSR_IRQ_EN adds the IRQ port and IE storage.
module avalon_crypto_csr
   import crypto_csr_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int KEY_WORDS = 4,
   parameter int MSG_WORDS = 4,
   parameter int ADDR_W    = 4
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic                          AVL_READ,
   input  logic                          AVL_WRITE,
   input  logic                          AVL_CS,
   input  logic [DATA_W/8-1:0]           AVL_BYTE_EN,
   input  logic [ADDR_W-1:0]             AVL_ADDR,
   input  logic [DATA_W-1:0]             AVL_WRITEDATA,
   output logic [DATA_W-1:0]             AVL_READDATA,
   output logic [DATA_W-1:0]             EXPORT_DATA,
   output logic                          CORE_START,
   output logic                          CORE_CLR,
   output logic [KEY_WORDS*DATA_W-1:0]   CORE_KEY,
   output logic [MSG_WORDS*DATA_W-1:0]   CORE_MSG_IN,
   input  logic [MSG_WORDS*DATA_W-1:0]   CORE_MSG_OUT,
   input  logic                          CORE_DONE
`ifdef CRYPTO_CSR_IRQ_EN
   ,
   output logic                          IRQ
`endif
);

   localparam int NB    = DATA_W / 8;
   localparam int CNT_W = DATA_W / 2;
   localparam int IN_B  = in_base(KEY_WORDS);
   localparam int OUT_B = out_base(KEY_WORDS, MSG_WORDS);
   localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(ctrl_addr(ADDR_W));
   localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(status_addr(ADDR_W));

   if (2*MSG_WORDS + KEY_WORDS + 2 > (1 << ADDR_W)) begin : g_map_chk
      $error("avalon_crypto_csr: register map does not fit in ADDR_W");
   end

   logic [KEY_WORDS-1:0][DATA_W-1:0] key_q;
   logic [MSG_WORDS-1:0][DATA_W-1:0] in_q;
   logic [MSG_WORDS-1:0][DATA_W-1:0] out_q;
   logic                             done_q, err_q, ie_q;
   logic                             busy, capture;
   logic [CNT_W-1:0]                 op_cnt;
   logic [DATA_W-1:0]                rd_word;
   logic                             wr, ctrl_wr, stat_wr, data_wr;
   logic                             start_bit, start_req, abort_req, err_set;

   function automatic logic [DATA_W-1:0] merge_be(input logic [DATA_W-1:0] old_w,
                                                  input logic [DATA_W-1:0] new_w,
                                                  input logic [NB-1:0]     be);
      merge_be = old_w;
      for (int b = 0; b < NB; b++)
         if (be[b]) merge_be[b*8 +: 8] = new_w[b*8 +: 8];
   endfunction

   // Control bits all live in byte lane 0
   assign wr        = AVL_WRITE & AVL_CS;
   assign ctrl_wr   = wr & (AVL_ADDR == A_CTRL) & AVL_BYTE_EN[0];
   assign stat_wr   = wr & (AVL_ADDR == A_STAT) & AVL_BYTE_EN[0];
   assign data_wr   = wr & (int'(AVL_ADDR) < OUT_B);
   assign start_bit = ctrl_wr & AVL_WRITEDATA[CTRL_START];
   assign abort_req = ctrl_wr & AVL_WRITEDATA[CTRL_ABORT];
   assign start_req = start_bit & ~abort_req & ~busy;
   assign err_set   = busy & (data_wr | (start_bit & ~abort_req));

   crypto_csr_fsm #(.CNT_W(CNT_W)) u_fsm (
      .CLK        (CLK),
      .RESET      (RESET),
      .start_req  (start_req),
      .abort_req  (abort_req),
      .CORE_DONE  (CORE_DONE),
      .CORE_START (CORE_START),
      .CORE_CLR   (CORE_CLR),
      .busy       (busy),
      .capture    (capture),
      .op_count   (op_cnt)
   );

   // KEY/IN byte-lane writes (dropped while busy); OUT loads the core result
   always_ff @(posedge CLK) begin
      if (RESET) begin
         key_q <= '0;
         in_q  <= '0;
         out_q <= '0;
      end else begin
         for (int i = 0; i < KEY_WORDS; i++)
            if (data_wr && !busy && AVL_ADDR == ADDR_W'(i))
               key_q[i] <= merge_be(key_q[i], AVL_WRITEDATA, AVL_BYTE_EN);
         for (int i = 0; i < MSG_WORDS; i++)
            if (data_wr && !busy && AVL_ADDR == ADDR_W'(IN_B + i))
               in_q[i] <= merge_be(in_q[i], AVL_WRITEDATA, AVL_BYTE_EN);
         if (capture)
            for (int i = 0; i < MSG_WORDS; i++)
               out_q[i] <= CORE_MSG_OUT[(MSG_WORDS-1-i)*DATA_W +: DATA_W];
      end
   end

   // Sticky DONE/ERR with write-1-to-clear; a hardware set beats a same-cycle clear
   always_ff @(posedge CLK) begin
      if (RESET) begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         if (capture)
            done_q <= 1'b1;
         else if (start_req || (stat_wr && AVL_WRITEDATA[STAT_DONE]))
            done_q <= 1'b0;
         if (err_set)
            err_q <= 1'b1;
         else if (stat_wr && AVL_WRITEDATA[STAT_ERR])
            err_q <= 1'b0;
      end
   end

`ifdef CRYPTO_CSR_IRQ_EN
   logic irq_q;

   // IE is writable at any time; IRQ is a registered IE & DONE
   always_ff @(posedge CLK) begin
      if (RESET) begin
         ie_q  <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         if (ctrl_wr) ie_q <= AVL_WRITEDATA[CTRL_IE];
         irq_q <= ie_q & done_q;
      end
   end

   assign IRQ = irq_q;
`else
   assign ie_q = 1'b0;
`endif

   // Read word select; unmapped addresses and action bits read as zero
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < KEY_WORDS; i++)
         if (AVL_ADDR == ADDR_W'(i)) rd_word = key_q[i];
      for (int i = 0; i < MSG_WORDS; i++) begin
         if (AVL_ADDR == ADDR_W'(IN_B + i))  rd_word = in_q[i];
         if (AVL_ADDR == ADDR_W'(OUT_B + i)) rd_word = out_q[i];
      end
      if (AVL_ADDR == A_CTRL) rd_word[CTRL_IE] = ie_q;
      if (AVL_ADDR == A_STAT) begin
         rd_word[DATA_W-1:CNT_W] = op_cnt;
         rd_word[STAT_DONE]      = done_q;
         rd_word[STAT_BUSY]      = busy;
         rd_word[STAT_ERR]       = err_q;
      end
   end

   // Registered read port, holds between reads
   always_ff @(posedge CLK) begin
      if (RESET)                  AVL_READDATA <= '0;
      else if (AVL_READ && AVL_CS) AVL_READDATA <= rd_word;
   end

   // Lowest-address word lands in the most significant slot
   for (genvar i = 0; i < KEY_WORDS; i++) begin : g_key
      assign CORE_KEY[(KEY_WORDS-1-i)*DATA_W +: DATA_W] = key_q[i];
   end
   for (genvar i = 0; i < MSG_WORDS; i++) begin : g_msg
      assign CORE_MSG_IN[(MSG_WORDS-1-i)*DATA_W +: DATA_W] = in_q[i];
   end

   assign EXPORT_DATA = {out_q[0][DATA_W-1:CNT_W], out_q[MSG_WORDS-1][CNT_W-1:0]};

endmodule

// File: tb/tb_avalon_crypto_csr.sv
// Self-checking bench for avalon_crypto_csr (default parameters). A
// transaction-level model of the register map and operation lifecycle
// predicts every output each cycle; a simple core stand-in answers launches.
module tb_avalon_crypto_csr;

   localparam int K      = 4;
   localparam int M      = 4;
   localparam int A_CTRL = 14;
   localparam int A_STAT = 15;
`ifdef CRYPTO_CSR_IRQ_EN
   localparam logic [31:0] C_IDLE = 32'h4, C_START = 32'h5, C_ABORT = 32'h6;
`else
   localparam logic [31:0] C_IDLE = 32'h0, C_START = 32'h1, C_ABORT = 32'h2;
`endif

   logic         CLK = 1'b0, RESET = 1'b1;
   logic         AVL_READ = 1'b0, AVL_WRITE = 1'b0, AVL_CS = 1'b0;
   logic [3:0]   AVL_BYTE_EN = '0;
   logic [3:0]   AVL_ADDR = '0;
   logic [31:0]  AVL_WRITEDATA = '0;
   logic [31:0]  AVL_READDATA, EXPORT_DATA;
   logic         CORE_START, CORE_CLR;
   logic         CORE_DONE = 1'b0;
   logic [127:0] CORE_KEY, CORE_MSG_IN;
   logic [127:0] CORE_MSG_OUT = '0;
`ifdef CRYPTO_CSR_IRQ_EN
   logic         IRQ;
`endif

   avalon_crypto_csr dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .AVL_READ      (AVL_READ),
      .AVL_WRITE     (AVL_WRITE),
      .AVL_CS        (AVL_CS),
      .AVL_BYTE_EN   (AVL_BYTE_EN),
      .AVL_ADDR      (AVL_ADDR),
      .AVL_WRITEDATA (AVL_WRITEDATA),
      .AVL_READDATA  (AVL_READDATA),
      .EXPORT_DATA   (EXPORT_DATA),
      .CORE_START    (CORE_START),
      .CORE_CLR      (CORE_CLR),
      .CORE_KEY      (CORE_KEY),
      .CORE_MSG_IN   (CORE_MSG_IN),
      .CORE_MSG_OUT  (CORE_MSG_OUT),
      .CORE_DONE     (CORE_DONE)
`ifdef CRYPTO_CSR_IRQ_EN
      , .IRQ         (IRQ)
`endif
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog");
   end

   int n_chk = 0, n_err = 0;

   // reference model state
   logic [31:0] m_key[K], m_in[M], m_out[M];
   logic        m_done, m_err, m_ie, m_active, m_irq;
   int          m_since;
   logic [15:0] m_cnt;
   logic [31:0] m_rd;

   // core stand-in
   int           core_timer = 0;
   int           next_delay = 10;
   logic [127:0] next_result = '0;

   logic [31:0] key_vals[K], in_vals[M];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      for (int i = 0; i < K; i++) m_key[i] = '0;
      for (int i = 0; i < M; i++) begin m_in[i] = '0; m_out[i] = '0; end
      m_done = 0; m_err = 0; m_ie = 0; m_active = 0; m_irq = 0;
      m_since = 0; m_cnt = '0; m_rd = '0;
   endtask

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_read(input int a);
      if (a < K)       return m_key[a];
      if (a < K+M)     return m_in[a-K];
      if (a < K+2*M)   return m_out[a-K-M];
      if (a == A_CTRL) return {29'd0, m_ie, 2'b00};
      if (a == A_STAT) return {m_cnt, 13'd0, m_err, m_active, m_done};
      return 32'd0;
   endfunction

   // One clock: advance the model from the driven inputs, clock, compare, move the core stand-in
   task automatic step();
      logic wr, st, ab, launch, clr, cap, eset, w1c_d, w1c_e;
      int   a;
      launch = 0; clr = 0; cap = 0; eset = 0;
      a  = int'(AVL_ADDR);
      wr = AVL_WRITE && AVL_CS;
      if (RESET) begin
         reset_model();
      end else begin
`ifdef CRYPTO_CSR_IRQ_EN
         m_irq = m_ie & m_done;
`endif
         if (AVL_READ && AVL_CS) m_rd = model_read(a);
         st    = wr && a == A_CTRL && AVL_BYTE_EN[0] && AVL_WRITEDATA[0];
         ab    = wr && a == A_CTRL && AVL_BYTE_EN[0] && AVL_WRITEDATA[1];
         w1c_d = wr && a == A_STAT && AVL_BYTE_EN[0] && AVL_WRITEDATA[0];
         w1c_e = wr && a == A_STAT && AVL_BYTE_EN[0] && AVL_WRITEDATA[2];
         if (wr && a < K+M) begin
            if (m_active)   eset = 1;
            else if (a < K) m_key[a]  = merge(m_key[a],  AVL_WRITEDATA, AVL_BYTE_EN);
            else            m_in[a-K] = merge(m_in[a-K], AVL_WRITEDATA, AVL_BYTE_EN);
         end
         if (m_active && st && !ab) eset = 1;
         if (!m_active) begin
            if (st && !ab) begin m_active = 1; m_since = 0; launch = 1; end
         end else begin
            if (ab) begin
               m_active = 0; clr = 1;
            end else if (m_since > 0 && CORE_DONE) begin
               m_active = 0; cap = 1; m_cnt++;
               for (int i = 0; i < M; i++) m_out[i] = CORE_MSG_OUT[(M-1-i)*32 +: 32];
            end
            m_since++;
         end
         if (cap) m_done = 1;
         else if (launch || w1c_d) m_done = 0;
         if (eset) m_err = 1;
         else if (w1c_e) m_err = 0;
`ifdef CRYPTO_CSR_IRQ_EN
         if (wr && a == A_CTRL && AVL_BYTE_EN[0]) m_ie = AVL_WRITEDATA[2];
`endif
      end
      @(posedge CLK); #1;
      chk("core_start",  128'(CORE_START),   128'(launch));
      chk("core_clr",    128'(CORE_CLR),     128'(clr));
      chk("readdata",    128'(AVL_READDATA), 128'(m_rd));
      chk("core_key",    CORE_KEY,    {m_key[0], m_key[1], m_key[2], m_key[3]});
      chk("core_msg_in", CORE_MSG_IN, {m_in[0], m_in[1], m_in[2], m_in[3]});
      chk("export_data", 128'(EXPORT_DATA), 128'({m_out[0][31:16], m_out[M-1][15:0]}));
`ifdef CRYPTO_CSR_IRQ_EN
      chk("irq",         128'(IRQ),          128'(m_irq));
`endif
      if (RESET) core_timer = 0;
      else if (launch) begin core_timer = next_delay; CORE_MSG_OUT = next_result; end
      else if (core_timer > 0) core_timer--;
      CORE_DONE = (core_timer == 1);
   endtask

   task automatic wr_bus(input int a, input logic [31:0] d, input logic [3:0] be = 4'hF);
      AVL_WRITE = 1; AVL_CS = 1; AVL_ADDR = 4'(a); AVL_WRITEDATA = d; AVL_BYTE_EN = be;
      step();
      AVL_WRITE = 0; AVL_CS = 0; AVL_BYTE_EN = '0;
   endtask

   task automatic rd_bus(input int a);
      AVL_READ = 1; AVL_CS = 1; AVL_ADDR = 4'(a);
      step();
      AVL_READ = 0; AVL_CS = 0;
   endtask

   initial begin
      reset_model();
      RESET = 1;
      repeat (3) step();
      RESET = 0;

      // every address reads zero after reset
      for (int a = 0; a < 16; a++) begin
         rd_bus(a);
         chk("reset_read", 128'(AVL_READDATA), 128'(32'h0));
      end

      // load KEY and IN, read them back
      for (int i = 0; i < K; i++) key_vals[i] = 32'h00010203 + 32'h04040404 * i;
      in_vals[0] = 32'hDAFAC5A1; in_vals[1] = 32'h13579BDF;
      in_vals[2] = 32'h2468ACE0; in_vals[3] = 32'h0F1E2D3C;
      for (int i = 0; i < K; i++) wr_bus(i, key_vals[i]);
      for (int i = 0; i < M; i++) wr_bus(K + i, in_vals[i]);
      for (int a = 0; a < K + M; a++) rd_bus(a);
      chk("in3_readback", 128'(AVL_READDATA), 128'(in_vals[3]));
      wr_bus(A_CTRL, C_IDLE);

      // first operation, polling STATUS while busy
      next_delay  = 10;
      next_result = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
      wr_bus(A_CTRL, C_START);
      for (int n = 0; n < 40 && m_active; n++) rd_bus(A_STAT);
      rd_bus(A_STAT);
      chk("op1_status", 128'(AVL_READDATA), 128'(32'h0001_0001));
      rd_bus(K + M);
      chk("op1_out0", 128'(AVL_READDATA), 128'(32'hDEADBEEF));
      rd_bus(K + M + 3);
      chk("op1_out3", 128'(AVL_READDATA), 128'(32'hCAFEF00D));
      idle_hold_check();

      // single byte lane write
      wr_bus(K, 32'hAABBCCDD, 4'b0100);
      rd_bus(K);
      chk("in0_byte_en", 128'(AVL_READDATA), 128'({in_vals[0][31:24], 8'hBB, in_vals[0][15:0]}));

      // writes locked while busy set ERR, then W1C
      next_delay  = 20;
      next_result = {$urandom, $urandom, $urandom, $urandom};
      wr_bus(A_CTRL, C_START);
      wr_bus(0, 32'hFFFF_FFFF);
      rd_bus(0);
      chk("key_locked", 128'(AVL_READDATA), 128'(key_vals[0]));
      rd_bus(A_STAT);
      chk("status_locked", 128'(AVL_READDATA), 128'(32'h0001_0006));
      for (int n = 0; n < 40 && m_active; n++) step();
      wr_bus(A_STAT, 32'h5);
      rd_bus(A_STAT);
      chk("status_w1c", 128'(AVL_READDATA), 128'(32'h0002_0000));

      // abort two cycles after launch; the late CORE_DONE is ignored
      next_delay  = 8;
      next_result = {$urandom, $urandom, $urandom, $urandom};
      wr_bus(A_CTRL, C_START);
      step();
      wr_bus(A_CTRL, C_ABORT);
      repeat (12) step();
      rd_bus(A_STAT);
      chk("abort_status", 128'(AVL_READDATA), 128'(32'h0002_0000));

      // CORE_DONE during LAUNCH is ignored, then abort
      next_delay = 1;
      wr_bus(A_CTRL, C_START);
      repeat (3) step();
      rd_bus(A_STAT);
      chk("launch_done_ignored", 128'(AVL_READDATA), 128'(32'h0002_0002));
      wr_bus(A_CTRL, C_ABORT);

      // abort while idle and START+ABORT together do nothing
      wr_bus(A_CTRL, C_ABORT);
      wr_bus(A_CTRL, C_START | C_ABORT);
      rd_bus(A_STAT);
      chk("no_launch", 128'(AVL_READDATA), 128'(32'h0002_0000));

      // W1C on the capture cycle loses to the set
      next_delay  = 5;
      next_result = {$urandom, $urandom, $urandom, $urandom};
      wr_bus(A_CTRL, C_START);
      for (int n = 0; n < 20 && !CORE_DONE; n++) step();
      wr_bus(A_STAT, 32'h1);
      rd_bus(A_STAT);
      chk("w1c_vs_set", 128'(AVL_READDATA), 128'(32'h0003_0001));
      step();
      wr_bus(A_STAT, 32'h1);
      repeat (2) step();

      // randomized traffic
      for (int it = 0; it < 400; it++) begin
         int op;
         op          = int'($urandom_range(0, 8));
         next_delay  = int'($urandom_range(2, 12));
         next_result = {$urandom, $urandom, $urandom, $urandom};
         AVL_CS        = ($urandom_range(0, 7) != 0);
         AVL_ADDR      = 4'($urandom_range(0, 15));
         AVL_WRITEDATA = $urandom;
         AVL_BYTE_EN   = 4'($urandom);
         case (op)
            0, 1, 2: AVL_WRITE = 1;
            3, 4, 5: AVL_READ  = 1;
            6: begin AVL_WRITE = 1; AVL_ADDR = 4'(A_CTRL); AVL_WRITEDATA = 32'($urandom_range(0, 7)); end
            7: begin AVL_WRITE = 1; AVL_ADDR = 4'(A_STAT); end
            default: ;
         endcase
         step();
         AVL_WRITE = 0; AVL_READ = 0; AVL_CS = 0;
      end

      // reset in the middle of an operation
      next_delay = 12;
      wr_bus(A_CTRL, C_START);
      repeat (2) step();
      RESET = 1;
      step();
      RESET = 0;
      rd_bus(A_STAT);
      chk("post_reset_status", 128'(AVL_READDATA), 128'(32'h0));
      repeat (14) step();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   // read data holds when no read is issued
   task automatic idle_hold_check();
      logic [31:0] held;
      held = AVL_READDATA;
      AVL_ADDR = 4'd0;
      repeat (2) step();
      chk("readdata_hold", 128'(AVL_READDATA), 128'(held));
   endtask

endmodule
